// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - run-time selectable VGA test-pattern source; define PATTERN_ANIM_EN for a per-frame gradient scroll
module vga_pattern_gen #(
  parameter int H_ACTIVE   = 800,
  parameter int V_ACTIVE   = 480,
  parameter int H_TOTAL    = 800,
  parameter int V_TOTAL    = 525,
  parameter int COLOR_W    = 8,
  parameter int CHECK_LOG2 = 5
) (
  input  logic                 vga_clk,
  input  logic                 arst,
  input  logic [2:0]           mode,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 active,
  output logic                 frame_start
);

  // Counter widths leave room for the H/V totals themselves so the
  // active-area compares never overflow when ACTIVE == TOTAL.
  localparam int XW      = $clog2(H_TOTAL + 1);
  localparam int YW      = $clog2(V_TOTAL + 1);
  localparam int BAR_PIX = H_ACTIVE / 8;
  localparam int BW      = $clog2(BAR_PIX + 1);

  localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] X_ACT    = XW'(H_ACTIVE);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] Y_ACT    = YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_BAND1  = YW'(V_ACTIVE / 3);
  localparam logic [YW-1:0] Y_BAND2  = YW'((2 * V_ACTIVE) / 3);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_PIX - 1);

  localparam logic [COLOR_W-1:0] MAX = '1;

  localparam logic [2:0] MODE_SOLID = 3'd0;
  localparam logic [2:0] MODE_BARS  = 3'd1;
  localparam logic [2:0] MODE_GRAD  = 3'd2;
  localparam logic [2:0] MODE_CHECK = 3'd3;
  localparam logic [2:0] MODE_BANDS = 3'd4;

  // Position, latched mode and bar tracking
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [2:0]    mode_q, mode_d;
  logic [2:0]    bar_q, bar_d;
  logic [BW-1:0] bpix_q, bpix_d;

  // Registered pixel outputs
  logic [COLOR_W-1:0] red_q, red_d;
  logic [COLOR_W-1:0] green_q, green_d;
  logic [COLOR_W-1:0] blue_q, blue_d;
  logic               active_q, active_d;
  logic               frame_start_q, frame_start_d;

  logic               line_end;
  logic               frame_end;
  logic               in_active;
  logic [COLOR_W-1:0] off;

  assign line_end  = (x_q == X_LAST);
  assign frame_end = line_end && (y_q == Y_LAST);
  assign in_active = (x_q < X_ACT) && (y_q < Y_ACT);

`ifdef PATTERN_ANIM_EN
  logic [COLOR_W-1:0] off_q, off_d;

  // Gradient offset advances once per frame, on the same edge as the mode latch
  always_comb begin
    off_d = off_q;
    if (frame_end) begin
      off_d = off_q + 1'b1;
    end
  end

  // Offset register
  always_ff @(posedge vga_clk or posedge arst) begin
    if (arst) begin
      off_q <= '0;
    end else begin
      off_q <= off_d;
    end
  end

  assign off = off_q;
`else
  assign off = '0;
`endif

  // x/y raster counters; both wrap together at the frame boundary
  always_comb begin
    x_d = x_q + 1'b1;
    y_d = y_q;
    if (line_end) begin
      x_d = '0;
      y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
    end
  end

  // Mode is only picked up at the frame boundary so a frame is never torn
  always_comb begin
    mode_d = mode_q;
    if (frame_end) begin
      mode_d = mode;
    end
  end

  // Bar index follows x by counting pixels per bar instead of dividing;
  // it parks at the last bar through horizontal blanking
  always_comb begin
    bar_d  = bar_q;
    bpix_d = bpix_q + 1'b1;
    if (line_end) begin
      bar_d  = '0;
      bpix_d = '0;
    end else if (bpix_q == BAR_LAST) begin
      bpix_d = '0;
      if (bar_q != 3'd7) begin
        bar_d = bar_q + 1'b1;
      end
    end
  end

  // Position, mode and bar state registers
  always_ff @(posedge vga_clk or posedge arst) begin
    if (arst) begin
      x_q    <= '0;
      y_q    <= '0;
      mode_q <= '0;
      bar_q  <= '0;
      bpix_q <= '0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      mode_q <= mode_d;
      bar_q  <= bar_d;
      bpix_q <= bpix_d;
    end
  end

  // Pixel function of the current (x, y, mode_q); blanking forces black
  always_comb begin
    red_d         = '0;
    green_d       = '0;
    blue_d        = '0;
    active_d      = in_active;
    frame_start_d = (x_q == '0) && (y_q == '0);

    case (mode_q)
      MODE_SOLID: begin
        red_d   = solid_rgb[3*COLOR_W-1:2*COLOR_W];
        green_d = solid_rgb[2*COLOR_W-1:COLOR_W];
        blue_d  = solid_rgb[COLOR_W-1:0];
      end
      MODE_BARS: begin
        red_d   = bar_q[1] ? '0 : MAX;
        green_d = bar_q[2] ? '0 : MAX;
        blue_d  = bar_q[0] ? '0 : MAX;
      end
      MODE_GRAD: begin
        red_d   = COLOR_W'(32'(x_q) + 32'(off));
        green_d = COLOR_W'(32'(y_q) + 32'(off));
        blue_d  = COLOR_W'(32'(x_q) + 32'(y_q) + 32'(off));
      end
      MODE_CHECK: begin
        if (x_q[CHECK_LOG2] ^ y_q[CHECK_LOG2]) begin
          red_d   = MAX;
          green_d = MAX;
          blue_d  = MAX;
        end
      end
      MODE_BANDS: begin
        if (y_q < Y_BAND1) begin
          red_d = MAX;
        end else if (y_q < Y_BAND2) begin
          green_d = MAX;
        end else begin
          blue_d = MAX;
        end
      end
      default: begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
      end
    endcase

    if (!in_active) begin
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
    end
  end

  // Output registers: one cycle from counter state to pixel
  always_ff @(posedge vga_clk or posedge arst) begin
    if (arst) begin
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign active      = active_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - self-checking bench for vga_pattern_gen
module tb_vga_pattern_gen;

  localparam int H_ACTIVE   = 304;
  localparam int V_ACTIVE   = 12;
  localparam int H_TOTAL    = 312;
  localparam int V_TOTAL    = 14;
  localparam int COLOR_W    = 8;
  localparam int CHECK_LOG2 = 3;
  localparam int FRAME_CYC  = H_TOTAL * V_TOTAL;
  localparam int ACT_CYC    = H_ACTIVE * V_ACTIVE;
  localparam int SWITCH_AT  = 6 * H_TOTAL + 200;
  localparam int LAST_FRAME = 7;

`ifdef PATTERN_ANIM_EN
  localparam bit ANIM = 1'b1;
`else
  localparam bit ANIM = 1'b0;
`endif

  logic        vga_clk = 1'b0;
  logic        arst;
  logic [2:0]  mode;
  logic [23:0] solid_rgb;
  logic [7:0]  red, green, blue;
  logic        active, frame_start;

  always #5 vga_clk = ~vga_clk;

  vga_pattern_gen #(
    .H_ACTIVE  (H_ACTIVE),
    .V_ACTIVE  (V_ACTIVE),
    .H_TOTAL   (H_TOTAL),
    .V_TOTAL   (V_TOTAL),
    .COLOR_W   (COLOR_W),
    .CHECK_LOG2(CHECK_LOG2)
  ) dut (
    .vga_clk    (vga_clk),
    .arst       (arst),
    .mode       (mode),
    .solid_rgb  (solid_rgb),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .active     (active),
    .frame_start(frame_start)
  );

  typedef struct {
    int          f;
    int          x;
    int          y;
    logic [23:0] solid;
    logic [23:0] rgb;
    logic        act;
    logic        fs;
  } vec_t;

  typedef struct {
    int          idx;
    logic [25:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   total = 0;
  int   bad   = 0;

  // mode input driven early in each frame (must be ignored) and from SWITCH_AT on (latched)
  int mode_early[8] = '{5, 3, 6, 4, 4, 1, 0, 2};
  int mode_late[8]  = '{1, 2, 3, 4, 0, 7, 2, 2};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  task automatic addv(input int f, input int x, input int y, input logic [23:0] s,
                      input logic [23:0] rgb, input logic act);
    vec_t v;
    v.f = f; v.x = x; v.y = y; v.solid = s; v.rgb = rgb; v.act = act;
    v.fs = (x == 0 && y == 0);
    vecs.push_back(v);
  endtask

  function automatic logic [23:0] grad(input int x, input int y, input int off);
    logic [7:0] r, g, b;
    r = 8'(x + off);
    g = 8'(y + off);
    b = 8'(x + y + off);
    return {r, g, b};
  endfunction

  function automatic int offf(input int f);
    return ANIM ? f : 0;
  endfunction

  function automatic logic [25:0] outs();
    return {frame_start, active, red, green, blue};
  endfunction

  initial begin
    int   tx, ty, tf, vi, pos, per, actc;
    bit   have_fs;
    sb_t  e;
    vec_t v;

    // frame 0: solid
    addv(0,   0,  0, 24'hA5C3E1, 24'hA5C3E1, 1);
    addv(0, 100,  5, 24'h0F1E2D, 24'h0F1E2D, 1);
    addv(0, 310,  5, 24'h0F1E2D, 24'h000000, 0);
    addv(0,  20, 12, 24'h0F1E2D, 24'h000000, 0);
    addv(0, 311, 13, 24'h0F1E2D, 24'h000000, 0);
    // frame 1: colour bars, 38 pixels each
    addv(1,   0,  0, 24'h5A5A5A, 24'hFFFFFF, 1);
    addv(1,  48,  0, 24'h5A5A5A, 24'hFFFF00, 1);
    addv(1,  76,  1, 24'h5A5A5A, 24'h00FFFF, 1);
    addv(1, 120,  2, 24'h5A5A5A, 24'h00FF00, 1);
    addv(1, 152,  2, 24'h5A5A5A, 24'hFF00FF, 1);
    addv(1, 200,  3, 24'h5A5A5A, 24'hFF0000, 1);
    addv(1, 250,  3, 24'h5A5A5A, 24'h0000FF, 1);
    addv(1, 303,  3, 24'h5A5A5A, 24'h000000, 1);
    addv(1, 304,  3, 24'h5A5A5A, 24'h000000, 0);
    addv(1, 311,  3, 24'h5A5A5A, 24'h000000, 0);
    addv(1,   0,  4, 24'h5A5A5A, 24'hFFFFFF, 1);
    addv(1,  37,  4, 24'h5A5A5A, 24'hFFFFFF, 1);
    addv(1,  38,  4, 24'h5A5A5A, 24'hFFFF00, 1);
    addv(1,  50, 12, 24'h5A5A5A, 24'h000000, 0);
    // frame 2: gradient
    addv(2,   0,  0, 24'h00FF00, grad(0, 0, offf(2)), 1);
    addv(2,   5,  3, 24'h00FF00, grad(5, 3, offf(2)), 1);
    addv(2, 300, 10, 24'h00FF00, grad(300, 10, offf(2)), 1);
    addv(2, 305, 10, 24'h00FF00, 24'h000000, 0);
    addv(2, 255, 11, 24'h00FF00, grad(255, 11, offf(2)), 1);
    // frame 3: checkerboard, 8-pixel squares
    addv(3,   0,  0, 24'h777777, 24'h000000, 1);
    addv(3,   8,  0, 24'h777777, 24'hFFFFFF, 1);
    addv(3,  16,  0, 24'h777777, 24'h000000, 1);
    addv(3, 309,  1, 24'h777777, 24'h000000, 0);
    addv(3,  15,  7, 24'h777777, 24'hFFFFFF, 1);
    addv(3,   7,  8, 24'h777777, 24'hFFFFFF, 1);
    addv(3,   8,  8, 24'h777777, 24'h000000, 1);
    // frame 4: bands (rows 0-3 red, 4-7 green, 8-11 blue); mode input goes 4->0 at (200,6)
    addv(4,   0,  0, 24'h0F0F0F, 24'hFF0000, 1);
    addv(4, 100,  3, 24'h0F0F0F, 24'hFF0000, 1);
    addv(4,  50,  4, 24'h0F0F0F, 24'h00FF00, 1);
    addv(4, 200,  6, 24'h123456, 24'h00FF00, 1);
    addv(4, 250,  8, 24'h123456, 24'h0000FF, 1);
    addv(4, 303, 11, 24'h123456, 24'h0000FF, 1);
    addv(4,  10, 12, 24'h123456, 24'h000000, 0);
    // frame 5: solid picked up at the boundary
    addv(5,   0,  0, 24'h123456, 24'h123456, 1);
    addv(5, 150,  5, 24'h123456, 24'h123456, 1);
    // frame 6: mode 7 is black
    addv(6,   0,  0, 24'hFFFFFF, 24'h000000, 1);
    addv(6, 150,  5, 24'hFFFFFF, 24'h000000, 1);
    // frame 7: gradient again, then reset mid-frame
    addv(7,   0,  0, 24'hFFFFFF, grad(0, 0, offf(7)), 1);
    addv(7, 300, 10, 24'hFFFFFF, grad(300, 10, offf(7)), 1);

    arst = 1'b1;
    mode = 3'd0;
    solid_rgb = 24'h0;
    repeat (2) @(posedge vga_clk);
    #1;
    chk("reset_state", 32'(outs()), 32'h0);

    @(negedge vga_clk);
    arst = 1'b0;

    tx = 0; ty = 0; tf = 0; vi = 0; per = 0; actc = 0; have_fs = 1'b0;
    while (tf <= LAST_FRAME && vi < vecs.size()) begin
      pos  = ty * H_TOTAL + tx;
      mode = 3'((pos < SWITCH_AT) ? mode_early[tf] : mode_late[tf]);
      v = vecs[vi];
      if (v.f == tf && v.x == tx && v.y == ty) begin
        solid_rgb = v.solid;
        e.idx = vi;
        e.exp = {v.fs, v.act, v.rgb};
        sb.push_back(e);
        vi++;
      end

      @(posedge vga_clk);
      #1;

      if (frame_start) begin
        if (have_fs) begin
          chk($sformatf("frame_period_f%0d", tf), 32'(per), 32'(FRAME_CYC));
          chk($sformatf("active_count_f%0d", tf), 32'(actc), 32'(ACT_CYC));
        end
        have_fs = 1'b1;
        per  = 1;
        actc = active ? 1 : 0;
      end else begin
        per++;
        if (active) actc++;
      end

      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk($sformatf("vec%0d_f%0d_x%0d_y%0d", e.idx, vecs[e.idx].f, vecs[e.idx].x, vecs[e.idx].y),
            32'(outs()), 32'(e.exp));
      end

      if (tx == H_TOTAL - 1) begin
        tx = 0;
        if (ty == V_TOTAL - 1) begin
          ty = 0;
          tf++;
        end else begin
          ty++;
        end
      end else begin
        tx++;
      end
    end
    chk("all_vectors_applied", 32'(vi), 32'(vecs.size()));

    // asynchronous reset mid-frame while in gradient mode
    #1;
    arst = 1'b1;
    #1;
    chk("async_reset_outputs", 32'(outs()), 32'h0);
    repeat (2) begin
      @(posedge vga_clk);
      #1;
      chk("reset_hold_outputs", 32'(outs()), 32'h0);
    end
    mode = 3'd2;
    solid_rgb = 24'h000000;
    @(negedge vga_clk);
    arst = 1'b0;
    @(posedge vga_clk);
    #1;
    chk("post_reset_first_pixel", 32'(outs()), 32'({1'b1, 1'b1, 24'h000000}));
    solid_rgb = 24'h010203;
    @(posedge vga_clk);
    #1;
    chk("post_reset_mode_cleared", 32'(outs()), 32'({1'b0, 1'b1, 24'h010203}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Parametrised VGA test-pattern source. It replaces the fixed per-image generators with one block that tracks pixel position as separate x/y counters and has run-time selectable patterns: solid, colour bars, gradient, checkerboard and RGB bands. It sits between the pixel clock domain and the VGA timing/DAC stage and drives registered RGB plus active and frame-start qualifiers. Mode changes take effect only on a frame boundary, so no frame is ever torn.

## Interface
- H_ACTIVE, 800: visible pixels per line; must be a multiple of 8.
- V_ACTIVE, 480: visible lines per frame; must be a multiple of 3.
- H_TOTAL, 800: total pixel slots per line, including blanking; must be ≥ H_ACTIVE.
- V_TOTAL, 525: total lines per frame; must be ≥ V_ACTIVE.
- COLOR_W, 8: bits per colour channel.
- CHECK_LOG2, 5: checker square edge is 2^CHECK_LOG2 pixels.

Ports (clock and reset first):
- vga_clk  in  1  pixel clock; all state updates on its rising edge.
- arst  in  1  reset, asynchronous, active-high; one clock; reset is asynchronous and active-high.
- mode  in  3  pattern select; sampled only at the frame boundary.
- solid_rgb  in  3*COLOR_W  colour for mode 0, packed {R,G,B}; sampled every cycle.
- red  out  COLOR_W  red channel, registered.
- green  out  COLOR_W  green channel, registered.
- blue  out  COLOR_W  blue channel, registered.
- active  out  1  high when the output pixel is inside H_ACTIVE×V_ACTIVE.
- frame_start  out  1  one-cycle pulse aligned with output pixel (0,0).

## Operation
- Counters:
  - x runs 0..H_TOTAL-1 and wraps to 0.
  - On the x wrap, y increments, running 0..V_TOTAL-1 and wrapping to 0.
- Frame boundary: the cycle where x=H_TOTAL-1 and y=V_TOTAL-1.
  - At that cycle, mode_q ← mode; it is used from pixel (0,0) onward.
  - Mode changes at any other time are ignored until the next boundary.
- Pixel function, evaluated on the current (x,y,mode_q); MAX = all ones:
  - 0 solid: {R,G,B} = solid_rgb.
  - 1 colour bars: 8 bars of width H_ACTIVE/8.
    - Bar index b is held in a bar counter, not computed by division.
    - R = b[1]?0:MAX, G = b[2]?0:MAX, B = b[0]?0:MAX.
    - Resulting order: white, yellow, cyan, green, magenta, red, blue, black.
  - 2 gradient, all values truncated to COLOR_W:
    - R = x + off
    - G = y + off
    - B = (x+y) + off
  - 3 checkerboard: x[CHECK_LOG2]^y[CHECK_LOG2] ? MAX on all channels : 0.
  - 4 RGB bands:
    - y < V_ACTIVE/3: pure red.
    - y < 2·V_ACTIVE/3: pure green.
    - otherwise: pure blue.
  - 5–7: black.
- Blanking: outside the active area, RGB = 0 and active = 0, for every mode.
- off: 0 unless animation is enabled (see Configuration).

## Timing
- Latency: exactly 1 cycle from counter state (x,y) to the registered red/green/blue/active/frame_start for that pixel.
- Reset (arst high, asynchronous):
  - x, y, mode_q, off, bar counter, red, green, blue, active and frame_start all become 0 immediately.
  - All of them stay 0 while arst is held.
- After release:
  - First rising edge: outputs show pixel (0,0) with frame_start=1; counters advance to (1,0).
  - Frame period: exactly H_TOTAL·V_TOTAL cycles between frame_start pulses.
- Reset mid-frame: counters restart at (0,0) and mode_q returns to 0; there is no partial-frame carry-over.
- Simultaneous x wrap and y wrap (frame boundary): both wrap in the same cycle; the mode_q and off updates occur on that same edge.
- Bar counter: resets to 0 at x=0 and saturates at 7 through blanking.

## Configuration
- PATTERN_ANIM_EN defined:
  - 8-bit-wide (COLOR_W) register off increments by 1 at every frame boundary, wrapping modulo 2^COLOR_W.
  - Gradient mode scrolls one step per frame.
- PATTERN_ANIM_EN undefined:
  - off is the constant 0 and no register is built.
  - Gradient is static.

## Test plan
- Assert arst mid-frame in mode 2 → all outputs read 0 while arst is held; first edge after release gives frame_start=1, RGB=(0,0,0), active=1.
- Mode 1, defaults → x=0 gives (FF,FF,FF), x=150 gives (FF,FF,00), x=799 gives (00,00,00); x=800..799 of blanking (y≥480) gives 0 and active=0.
- Mode 2, no macro → pixel (300,10) gives R=0x2C, G=0x0A, B=0x36. With PATTERN_ANIM_EN, third frame after reset gives R=0x2E, G=0x0C, B=0x38.
- Mode 3 → (32,0) white, (32,32) black, (0,0) black, (63,31) white.
- Change mode 4→0 at pixel (400,200) with solid_rgb=0x123456 → remainder of frame stays in bands (y=200 green); next frame_start pixel reads (12,34,56).
- Count cycles between frame_start pulses → exactly 420000; active high for exactly 384000 of them.
